// File: rtl/depth_smoother_pkg.sv
// ---------------------------------------------------------------------------
// depth_pkg
// Shared definitions for the depth smoother: word width, history depth,
// filter state encoding and the reject-counter saturation value.
// ---------------------------------------------------------------------------
package depth_pkg;

   localparam int unsigned DW    = 15;  // depth word width
   localparam int unsigned DEPTH = 8;   // history depth, power of two

   localparam logic [7:0] REJ_MAX = 8'hFF;

   typedef enum logic [1:0] {
      FLUSH  = 2'd0,
      FILL   = 2'd1,
      RUN    = 2'd2,
      BYPASS = 2'd3
   } state_e;

endpackage

// File: rtl/depth_smoother_hist_ram.sv
// ---------------------------------------------------------------------------
// depth_hist_ram
// DEPTH x DW register file holding the moving-average history.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   clr_i      : synchronous clear of every entry
//   we_i       : write enable for waddr_i / wdata_i
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_i    : asynchronous read address
//   rdata_o    : read data at raddr_i
// ---------------------------------------------------------------------------
module depth_hist_ram #(
   parameter int unsigned DW    = depth_pkg::DW,
   parameter int unsigned DEPTH = depth_pkg::DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DW-1:0]            wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DW-1:0]            rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/depth_smoother.sv
// ---------------------------------------------------------------------------
// depth_smoother
// Streaming post-filter for histogram depth values. Rejects samples that are
// zero or above TDC_Range, averages accepted samples over a power-of-two
// window (1/2/4/8) and emits the result through a single output register.
// Ports:
//   clk, rst_n  : 250 MHz logic clock, asynchronous active-low reset
//   DEP_En      : 1 = filter, 0 = bypass (valid samples forwarded unchanged)
//   DEP_Win     : window size N = 1 << DEP_Win
//   TDC_Range   : inclusive upper bound for a valid depth
//   HIS_Odata   : input depth, with HIS_Ovalid / HIS_Oready handshake
//   DEP_Odata   : filtered depth, with DEP_Ovalid / DEP_Oready handshake
//   DEP_Orej    : saturating count of rejected samples (cleared by reset only)
// ---------------------------------------------------------------------------
module depth_smoother #(
   parameter int unsigned DW    = depth_pkg::DW,
   parameter int unsigned DEPTH = depth_pkg::DEPTH
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          DEP_En,
   input  logic [1:0]    DEP_Win,
   input  logic [DW-1:0] TDC_Range,
   input  logic [DW-1:0] HIS_Odata,
   input  logic          HIS_Ovalid,
   output logic          HIS_Oready,
   output logic [DW-1:0] DEP_Odata,
   output logic          DEP_Ovalid,
   input  logic          DEP_Oready,
   output logic [7:0]    DEP_Orej
);

   import depth_pkg::state_e;
   import depth_pkg::FLUSH;
   import depth_pkg::FILL;
   import depth_pkg::RUN;
   import depth_pkg::BYPASS;
   import depth_pkg::REJ_MAX;

   localparam int unsigned AW = $clog2(DEPTH);  // history pointer width
   localparam int unsigned CW = AW + 1;         // fill count, 0..DEPTH
   localparam int unsigned SW = DW + 3;         // running sum of up to 8 words

   state_e          state_q, state_d;
   logic [1:0]      win_q;
   logic            en_q;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   fill_q, fill_d;
   logic [SW-1:0]   sum_q, sum_d;
   logic [DW-1:0]   odata_q, odata_d;
   logic            ovalid_q, ovalid_d;
   logic [7:0]      rej_q, rej_d;

   logic [CW-1:0]   n_win;
   logic [CW-1:0]   fill_inc;
   logic            flush_req;
   logic            in_ready;
   logic            in_fire;
   logic            reject;
   logic            accept;
   logic            produce;
   logic [DW-1:0]   result;
   logic            hist_we;
   logic            hist_clr;
   logic [AW-1:0]   rd_addr;
   logic [DW-1:0]   hist_rd;
   logic [SW-1:0]   sum_add;
   logic [SW-1:0]   sum_run;

   depth_hist_ram #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_hist (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (hist_clr),
      .we_i    (hist_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (HIS_Odata),
      .raddr_i (rd_addr),
      .rdata_o (hist_rd)
   );

   assign n_win    = CW'(1) << DEP_Win;
   assign fill_inc = fill_q + CW'(1);
   // Oldest sample of the window; modulo DEPTH via pointer truncation.
   assign rd_addr  = wr_ptr_q - AW'(n_win);
   assign sum_add  = sum_q + SW'(HIS_Odata);
   assign sum_run  = sum_add - SW'(hist_rd);

   // A window change or enable rising is seen one cycle before the registered
   // FLUSH state; input is held off in that cycle too so no sample is ever
   // combined with history built for a different N.
   assign flush_req = DEP_En & (!en_q | (DEP_Win != win_q));
   assign in_ready  = (state_q != FLUSH) & !flush_req & (!ovalid_q | DEP_Oready);
   assign in_fire   = HIS_Ovalid & in_ready;
   assign reject    = (HIS_Odata == '0) | (HIS_Odata > TDC_Range);
   assign accept    = in_fire & !reject;

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      sum_d    = sum_q;
      produce  = 1'b0;
      result   = '0;
      hist_we  = 1'b0;
      hist_clr = 1'b0;

      if (!DEP_En) begin
         state_d = BYPASS;
         if (accept) begin
            produce = 1'b1;
            result  = HIS_Odata;
         end
      end else if (flush_req) begin
         state_d = FLUSH;
      end else begin
         unique case (state_q)
            FLUSH: begin
               hist_clr = 1'b1;
               wr_ptr_d = '0;
               fill_d   = '0;
               sum_d    = '0;
               state_d  = FILL;
            end
            FILL: begin
               if (accept) begin
                  hist_we  = 1'b1;
                  sum_d    = sum_add;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  fill_d   = fill_inc;
                  if (fill_inc == n_win) begin
                     produce = 1'b1;
                     result  = DW'(sum_add >> DEP_Win);
                     state_d = RUN;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  hist_we  = 1'b1;
                  sum_d    = sum_run;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  produce  = 1'b1;
                  result   = DW'(sum_run >> DEP_Win);
               end
            end
            BYPASS: begin
               state_d = FLUSH;
            end
            default: begin
               state_d = FLUSH;
            end
         endcase
      end

      ovalid_d = produce | (ovalid_q & !DEP_Oready);
      odata_d  = produce ? result : odata_q;
      rej_d    = (in_fire & reject & (rej_q != REJ_MAX)) ? rej_q + 8'd1 : rej_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FLUSH;
         win_q    <= '0;
         en_q     <= 1'b1;
         wr_ptr_q <= '0;
         fill_q   <= '0;
         sum_q    <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
         rej_q    <= '0;
      end else begin
         state_q  <= state_d;
         win_q    <= DEP_Win;
         en_q     <= DEP_En;
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         sum_q    <= sum_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
         rej_q    <= rej_d;
      end
   end

   assign HIS_Oready = in_ready;
   assign DEP_Odata  = odata_q;
   assign DEP_Ovalid = ovalid_q;
   assign DEP_Orej   = rej_q;

endmodule

// File: tb/tb_depth_smoother.sv
module tb_depth_smoother;

   logic        clk;
   logic        rst_n;
   logic        DEP_En;
   logic [1:0]  DEP_Win;
   logic [14:0] TDC_Range;
   logic [14:0] HIS_Odata;
   logic        HIS_Ovalid;
   logic        HIS_Oready;
   logic [14:0] DEP_Odata;
   logic        DEP_Ovalid;
   logic        DEP_Oready;
   logic [7:0]  DEP_Orej;

   int total = 0;
   int bad   = 0;
   int stalls = 0;
   logic [14:0] out_q[$];

   depth_smoother #(
      .DW    (15),
      .DEPTH (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .DEP_En     (DEP_En),
      .DEP_Win    (DEP_Win),
      .TDC_Range  (TDC_Range),
      .HIS_Odata  (HIS_Odata),
      .HIS_Ovalid (HIS_Ovalid),
      .HIS_Oready (HIS_Oready),
      .DEP_Odata  (DEP_Odata),
      .DEP_Ovalid (DEP_Ovalid),
      .DEP_Oready (DEP_Oready),
      .DEP_Orej   (DEP_Orej)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Output transfers are committed at the next rising edge; record them here.
   always @(negedge clk) begin
      if (rst_n && DEP_Ovalid && DEP_Oready) out_q.push_back(DEP_Odata);
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [14:0] d);
      int unsigned w;
      w = 0;
      HIS_Ovalid = 1'b1;
      HIS_Odata  = d;
      @(negedge clk);
      while (!HIS_Oready && w < 50) begin
         stalls++;
         w++;
         @(negedge clk);
      end
      if (!HIS_Oready) begin
         total++;
         bad++;
         $display("FAIL push_timeout data=%0d ready=%b required=1", d, HIS_Oready);
      end
      @(posedge clk);
      #1;
      HIS_Ovalid = 1'b0;
   endtask

   task automatic drain();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      DEP_En     = 1'b1;
      DEP_Win    = 2'd0;
      TDC_Range  = 15'd1000;
      HIS_Odata  = '0;
      HIS_Ovalid = 1'b0;
      DEP_Oready = 1'b1;
      #3;
      total++; if (DEP_Ovalid !== 1'b0) begin bad++; $display("FAIL rst_ovalid got=%b exp=0", DEP_Ovalid); end
      total++; if (DEP_Odata !== 15'd0) begin bad++; $display("FAIL rst_odata got=%0d exp=0", DEP_Odata); end
      total++; if (DEP_Orej !== 8'd0) begin bad++; $display("FAIL rst_orej got=%0d exp=0", DEP_Orej); end
      total++; if (HIS_Oready !== 1'b0) begin bad++; $display("FAIL rst_iready got=%b exp=0", HIS_Oready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (HIS_Oready !== 1'b0) begin bad++; $display("FAIL flush_iready got=%b exp=0", HIS_Oready); end
      @(posedge clk);
      #1;
      total++; if (HIS_Oready !== 1'b1) begin bad++; $display("FAIL fill_iready got=%b exp=1", HIS_Oready); end
   endtask

   task automatic test_fill_run();
      out_q.delete();
      DEP_Win   = 2'd2;
      TDC_Range = 15'd1000;
      push(15'd100);
      push(15'd200);
      push(15'd300);
      drain();
      total++; if (out_q.size() != 0) begin bad++; $display("FAIL fill_no_out got=%0d exp=0", out_q.size()); end
      push(15'd400);
      push(15'd500);
      drain();
      total++;
      if (out_q.size() != 2) begin
         bad++; $display("FAIL fill_run_count got=%0d exp=2", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd250) begin bad++; $display("FAIL fill_first got=%0d exp=250", out_q[0]); end
         total++; if (out_q[1] !== 15'd350) begin bad++; $display("FAIL run_second got=%0d exp=350", out_q[1]); end
      end
   endtask

   task automatic test_reject();
      out_q.delete();
      DEP_Win   = 2'd0;
      TDC_Range = 15'd328;
      push(15'd0);
      push(15'd400);
      push(15'd300);
      drain();
      total++;
      if (out_q.size() != 1) begin
         bad++; $display("FAIL rej_count_out got=%0d exp=1", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd300) begin bad++; $display("FAIL rej_pass got=%0d exp=300", out_q[0]); end
      end
      total++; if (DEP_Orej !== 8'd2) begin bad++; $display("FAIL rej_cnt2 got=%0d exp=2", DEP_Orej); end
      // inclusive upper bound
      push(15'd329);
      push(15'd328);
      drain();
      total++;
      if (out_q.size() != 2) begin
         bad++; $display("FAIL rej_bound_out got=%0d exp=2", out_q.size());
      end else begin
         total++; if (out_q[1] !== 15'd328) begin bad++; $display("FAIL rej_bound_val got=%0d exp=328", out_q[1]); end
      end
      total++; if (DEP_Orej !== 8'd3) begin bad++; $display("FAIL rej_cnt3 got=%0d exp=3", DEP_Orej); end
      for (int i = 0; i < 251; i++) push(15'd0);
      total++; if (DEP_Orej !== 8'd254) begin bad++; $display("FAIL rej_cnt254 got=%0d exp=254", DEP_Orej); end
      push(15'd0);
      total++; if (DEP_Orej !== 8'd255) begin bad++; $display("FAIL rej_cnt255 got=%0d exp=255", DEP_Orej); end
      for (int i = 0; i < 48; i++) push(15'd0);
      total++; if (DEP_Orej !== 8'd255) begin bad++; $display("FAIL rej_sat got=%0d exp=255", DEP_Orej); end
      drain();
      total++; if (out_q.size() != 2) begin bad++; $display("FAIL rej_no_extra got=%0d exp=2", out_q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [14:0] exp_v [5];
      int s0;
      exp_v[0] = 15'd11; exp_v[1] = 15'd22; exp_v[2] = 15'd33; exp_v[3] = 15'd44; exp_v[4] = 15'd55;
      out_q.delete();
      TDC_Range  = 15'd1000;
      DEP_Oready = 1'b0;
      HIS_Ovalid = 1'b1;
      HIS_Odata  = 15'd11;
      @(posedge clk);
      #1;
      total++; if (DEP_Ovalid !== 1'b1) begin bad++; $display("FAIL bp_ovalid got=%b exp=1", DEP_Ovalid); end
      HIS_Odata = 15'd22;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++; if (HIS_Oready !== 1'b0) begin bad++; $display("FAIL bp_iready cyc=%0d got=%b exp=0", i, HIS_Oready); end
         total++; if (DEP_Odata !== 15'd11) begin bad++; $display("FAIL bp_hold cyc=%0d got=%0d exp=11", i, DEP_Odata); end
      end
      DEP_Oready = 1'b1;
      s0 = stalls;
      push(15'd22);
      push(15'd33);
      push(15'd44);
      push(15'd55);
      total++; if (stalls != s0) begin bad++; $display("FAIL b2b_stalls got=%0d exp=0", stalls - s0); end
      drain();
      total++;
      if (out_q.size() != 5) begin
         bad++; $display("FAIL b2b_count got=%0d exp=5", out_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++; if (out_q[i] !== exp_v[i]) begin bad++; $display("FAIL b2b_data idx=%0d got=%0d exp=%0d", i, out_q[i], exp_v[i]); end
         end
      end
   endtask

   task automatic test_win_change();
      out_q.delete();
      DEP_Win = 2'd2;
      push(15'd4);
      push(15'd8);
      push(15'd12);
      push(15'd16);
      drain();
      total++;
      if (out_q.size() != 1) begin
         bad++; $display("FAIL win2_count got=%0d exp=1", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd10) begin bad++; $display("FAIL win2_val got=%0d exp=10", out_q[0]); end
      end
      out_q.delete();
      DEP_Win = 2'd1;
      @(posedge clk);
      #1;
      total++; if (HIS_Oready !== 1'b0) begin bad++; $display("FAIL winchg_flush got=%b exp=0", HIS_Oready); end
      @(posedge clk);
      #1;
      total++; if (HIS_Oready !== 1'b1) begin bad++; $display("FAIL winchg_fill got=%b exp=1", HIS_Oready); end
      push(15'd10);
      drain();
      total++; if (out_q.size() != 0) begin bad++; $display("FAIL win1_first got=%0d exp=0", out_q.size()); end
      push(15'd30);
      drain();
      total++;
      if (out_q.size() != 1) begin
         bad++; $display("FAIL win1_count got=%0d exp=1", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd20) begin bad++; $display("FAIL win1_val got=%0d exp=20", out_q[0]); end
      end
   endtask

   task automatic test_bypass_wrap();
      out_q.delete();
      DEP_En = 1'b0;
      push(15'd7);
      push(15'd0);
      push(15'd9);
      drain();
      total++;
      if (out_q.size() != 2) begin
         bad++; $display("FAIL byp_count got=%0d exp=2", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd7) begin bad++; $display("FAIL byp_v0 got=%0d exp=7", out_q[0]); end
         total++; if (out_q[1] !== 15'd9) begin bad++; $display("FAIL byp_v1 got=%0d exp=9", out_q[1]); end
      end
      out_q.delete();
      DEP_En  = 1'b1;
      DEP_Win = 2'd3;
      for (int j = 1; j <= 20; j++) push(15'(j));
      drain();
      // window of 8 ending at sample j sums to 8j-28, so average is j-4
      total++;
      if (out_q.size() != 13) begin
         bad++; $display("FAIL wrap_count got=%0d exp=13", out_q.size());
      end else begin
         for (int j = 8; j <= 20; j++) begin
            total++;
            if (out_q[j-8] !== 15'(j - 4)) begin
               bad++; $display("FAIL wrap_val sample=%0d got=%0d exp=%0d", j, out_q[j-8], j - 4);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      DEP_Oready = 1'b0;
      push(15'd21);
      total++; if (DEP_Ovalid !== 1'b1) begin bad++; $display("FAIL mid_pending got=%b exp=1", DEP_Ovalid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (DEP_Ovalid !== 1'b0) begin bad++; $display("FAIL mid_ovalid got=%b exp=0", DEP_Ovalid); end
      total++; if (DEP_Odata !== 15'd0) begin bad++; $display("FAIL mid_odata got=%0d exp=0", DEP_Odata); end
      total++; if (DEP_Orej !== 8'd0) begin bad++; $display("FAIL mid_orej got=%0d exp=0", DEP_Orej); end
      @(negedge clk);
      rst_n = 1'b1;
      DEP_Oready = 1'b1;
      out_q.delete();
      for (int i = 0; i < 7; i++) push(15'd40);
      drain();
      total++; if (out_q.size() != 0) begin bad++; $display("FAIL mid_refill got=%0d exp=0", out_q.size()); end
      push(15'd40);
      drain();
      total++;
      if (out_q.size() != 1) begin
         bad++; $display("FAIL mid_first_count got=%0d exp=1", out_q.size());
      end else begin
         total++; if (out_q[0] !== 15'd40) begin bad++; $display("FAIL mid_first_val got=%0d exp=40", out_q[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_fill_run();
      test_reject();
      test_back_to_back();
      test_win_change();
      test_bypass_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
